axi4_lite_master: RTL and testbench
===================================

// Module: axi4_lite_master
// PURPOSE
//  Synthesizable AXI4-Lite initiator; the master end of the axi4_lite interface that axi4_lite_mem serves.
//  Turns single-beat commands from local logic (cmd_*) into AXI4-Lite write/read transactions.
//  Returns one response (rsp_*) per command: resp code, read data, latency count.
//  One outstanding transaction at a time.
// PARAMETERS
//  ADDR_WIDTH  32            AXI address width
//  DATA_WIDTH  32            AXI data width; 32 or 64
//  PROT        3'b000        constant value driven on awprot/arprot
//  LAT_WIDTH   16            width of rsp_latency; saturates at all-ones
// PORTS
//  clk          in   1              system clock
//  rst          in   1              synchronous reset, active-high
//  cmd_valid    in   1              command request
//  cmd_ready    out  1              command accepted (IDLE only)
//  cmd_write    in   1              1=write, 0=read
//  cmd_addr     in   ADDR_WIDTH     target address
//  cmd_wdata    in   DATA_WIDTH     write data
//  cmd_wstrb    in   DATA_WIDTH/8   write byte strobes
//  rsp_valid    out  1              response available
//  rsp_ready    in   1              response consumed
//  rsp_resp     out  2              captured bresp/rresp
//  rsp_rdata    out  DATA_WIDTH     read data; 0 for writes
//  rsp_latency  out  LAT_WIDTH      cycles from cmd accept to B/R handshake
//  awaddr/awprot/awvalid  out; awready in  AW channel
//  wdata/wstrb/wvalid     out; wready  in  W channel
//  bresp/bvalid in;  bready out            B channel
//  araddr/arprot/arvalid  out; arready in  AR channel
//  rdata/rresp/rvalid     in;  rready out  R channel
// BEHAVIOUR
//  Reset: every valid/ready output=0, awaddr/araddr/wdata/wstrb=0, rsp_*=0, state=IDLE, cmd_ready=1.
//  All AXI and rsp outputs registered; no combinational path from any input to any output.
//  FSM: IDLE -> WR_ADDR_DATA -> WR_RESP -> RSP; IDLE -> RD_ADDR -> RD_DATA -> RSP; RSP -> IDLE.
//  IDLE: cmd_ready=1; on cmd_valid, latch cmd_*, clear latency, assert awvalid+wvalid (write)
//   or arvalid (read) the next cycle.
//  WR_ADDR_DATA: aw_done/w_done tracked independently. Each valid drops the cycle after its own ready.
//   awready and wready in the same cycle -> both done, enter WR_RESP next cycle.
//  WR_RESP: bready=1; on bvalid capture bresp, set rsp_rdata=0, bready=0, enter RSP.
//  RD_ADDR: arvalid held until arready. RD_DATA: rready=1; on rvalid capture rdata/rresp, go to RSP.
//  RSP: rsp_valid=1, held with data stable until rsp_ready; then IDLE (cmd_ready=1 the next cycle).
//  Protocol rules: valid never deasserted before ready; addr/data/strb stable while valid.
//   Valids never wait on readies. Bready/rready asserted only in WR_RESP/RD_DATA.
//  Minimum command-to-command spacing: IDLE(1)+addr(1)+resp(1)+RSP(1) = 4 cycles, zero-wait slave.
//  rsp_latency increments every cycle outside IDLE/RSP; saturates, never wraps.
//  cmd_valid during non-IDLE is ignored (cmd_ready=0); no queueing.
//  Low address bits are passed unmodified; the slave handles alignment.
//  rst mid-transaction: next edge forces reset values and abandons the transaction (the slave is reset by the same rst).
// STRUCTURE
//  axi4_lite_pkg: resp_t enum (OKAY=2'b00, EXOKAY=01, SLVERR=10, DECERR=11), mst_state_t enum.
//  Single module, no sub-modules. The axi4_lite master modport may wrap the flat ports at top level.
// TESTING (bench pairs the block with axi4_lite_mem, plus a stallable slave stub)
//  1 write 0x1<-0xAAAA_AAAA, strb 0xF -> one AW and one W handshake, rsp_resp=OKAY; read 0x1 -> rdata 0xAAAA_AAAA.
//  2 cmd_valid held, writes 0x2<-0x5555_5555 and 0x3<-0xF0F0_F0F0 -> second accepted only after first rsp handshake; readback matches.
//  3 stub: awready at cycle 1, wready at cycle 4 -> awvalid drops after cycle 1; wvalid/wdata stable through 4; rsp_latency=5.
//  4 rsp_ready low 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout.
//  5 rst pulsed during WR_RESP -> next cycle all valids/readies=0; cmd_ready=1 after release; new write succeeds.
//  6 stub returns rresp=SLVERR, rdata=0xDEAD_BEEF -> rsp_resp=2'b10, rsp_rdata=0xDEAD_BEEF.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite master: response codes and master FSM states.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } mst_state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-Lite initiator: one local command in, one AXI transaction out, one response back.
// All AXI and response outputs come straight from flops.
//
// state        | meaning
// IDLE         | cmd_ready=1, waiting for a command
// WR_ADDR_DATA | awvalid/wvalid up, each dropped after its own ready
// WR_RESP      | bready=1, waiting for bvalid
// RD_ADDR      | arvalid up, waiting for arready
// RD_DATA      | rready=1, waiting for rvalid
// RSP          | rsp_valid=1, held until rsp_ready
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [2:0]  PROT       = 3'b000,
  parameter int          LAT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_resp,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [LAT_WIDTH-1:0]    rsp_latency,

  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,

  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,

  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,

  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,

  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  mst_state_t state_q, state_d;

  logic [LAT_WIDTH-1:0]  lat_q, lat_d, lat_inc;
  logic                  cmd_ready_d;
  logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic                  awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_d;
  logic                  rsp_valid_d;
  logic [1:0]            rsp_resp_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;
  logic [LAT_WIDTH-1:0]  rsp_latency_d;

  assign awprot  = PROT;
  assign arprot  = PROT;
  assign lat_inc = (&lat_q) ? lat_q : lat_q + LAT_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    awaddr_d      = awaddr;
    awvalid_d     = awvalid;
    wdata_d       = wdata;
    wstrb_d       = wstrb;
    wvalid_d      = wvalid;
    bready_d      = bready;
    araddr_d      = araddr;
    arvalid_d     = arvalid;
    rready_d      = rready;
    rsp_valid_d   = rsp_valid;
    rsp_resp_d    = rsp_resp;
    rsp_rdata_d   = rsp_rdata;
    rsp_latency_d = rsp_latency;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          lat_d = '0;
          if (cmd_write) begin
            state_d   = WR_ADDR_DATA;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end

      // A channel already done has its valid low, so it no longer gates the exit.
      WR_ADDR_DATA: begin
        lat_d = lat_inc;
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end

      WR_RESP: begin
        lat_d = lat_inc;
        if (bvalid) begin
          state_d       = RSP;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = bresp;
          rsp_rdata_d   = '0;
          rsp_latency_d = lat_inc;
        end
      end

      RD_ADDR: begin
        lat_d = lat_inc;
        if (arready) begin
          state_d   = RD_DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end

      RD_DATA: begin
        lat_d = lat_inc;
        if (rvalid) begin
          state_d       = RSP;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = rresp;
          rsp_rdata_d   = rdata;
          rsp_latency_d = lat_inc;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      cmd_ready   <= 1'b1;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_resp    <= OKAY;
      rsp_rdata   <= '0;
      rsp_latency <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      cmd_ready   <= cmd_ready_d;
      awaddr      <= awaddr_d;
      awvalid     <= awvalid_d;
      wdata       <= wdata_d;
      wstrb       <= wstrb_d;
      wvalid      <= wvalid_d;
      bready      <= bready_d;
      araddr      <= araddr_d;
      arvalid     <= arvalid_d;
      rready      <= rready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_resp    <= rsp_resp_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_latency <= rsp_latency_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a small memory slave with stall and error knobs.
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_rdata;
  logic [15:0] rsp_latency;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int aw_hs = 0;
  int w_hs  = 0;

  int aw_wait = 0, w_wait = 0, b_wait = 0;
  logic err_mode = 1'b0;
  int aw_cnt, w_cnt, b_cnt;
  logic [31:0] mem [256];
  logic [7:0]  r_addr;

  always #5 clk = ~clk;

  axi4_lite_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000), .LAT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_rdata(rsp_rdata), .rsp_latency(rsp_latency),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  // Slave model: each ready comes after a programmable number of stall cycles.
  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign bvalid  = bready && (b_cnt >= b_wait);
  assign bresp   = 2'b00;
  assign arready = arvalid;
  assign rvalid  = rready;
  assign rresp   = err_mode ? 2'b10 : 2'b00;
  assign rdata   = err_mode ? 32'hDEAD_BEEF : mem[r_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst || !awvalid || awready) aw_cnt <= 0; else aw_cnt <= aw_cnt + 1;
    if (rst || !wvalid || wready)   w_cnt  <= 0; else w_cnt  <= w_cnt + 1;
    if (rst || !bready || bvalid)   b_cnt  <= 0; else b_cnt  <= b_cnt + 1;
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready)   w_hs  <= w_hs + 1;
    if (arvalid && arready) r_addr <= araddr[7:0];
    if (bvalid && bready)
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[awaddr[7:0]][i*8 +: 8] <= wdata[i*8 +: 8];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [1:0] r, output logic [31:0] d, output logic [15:0] l);
    int n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("rsp_wait", rsp_valid, 1'b1);
    r = rsp_resp; d = rsp_rdata; l = rsp_latency;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic [15:0] l;
    int          t_acc1, t_acc2, n;
    logic        seen_rsp;
    logic [1:0]  first_resp;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) tick();

    // Reset values
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
    chk("rst_readies", {bready, rready}, 2'b00);
    chk("rst_addr_data", {awaddr, araddr, wdata, wstrb}, '0);
    chk("rst_rsp", {rsp_resp, rsp_rdata, rsp_latency}, '0);
    chk("rst_prot", {awprot, arprot}, 6'b0);
    rst = 1'b0;
    tick();

    // 1: single write then read back, zero-wait slave
    issue(1'b1, 32'h1, 32'hAAAA_AAAA, 4'hF);
    wait_rsp(r, d, l);
    chk("t1_aw_hs", aw_hs, 1);
    chk("t1_w_hs", w_hs, 1);
    chk("t1_wr_resp", r, 2'b00);
    chk("t1_wr_rdata", d, 32'h0);
    chk("t1_wr_lat", l, 16'd2);
    issue(1'b0, 32'h1, 32'h0, 4'h0);
    wait_rsp(r, d, l);
    chk("t1_rd_data", d, 32'hAAAA_AAAA);
    chk("t1_rd_resp", r, 2'b00);
    chk("t1_rd_lat", l, 16'd2);

    // Partial strobes only touch enabled bytes
    issue(1'b1, 32'h8, 32'h1111_1111, 4'hF);
    wait_rsp(r, d, l);
    issue(1'b1, 32'h8, 32'h2233_4455, 4'b0101);
    wait_rsp(r, d, l);
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    wait_rsp(r, d, l);
    chk("strb_rd_data", d, 32'h1133_1155);

    // 2: cmd_valid held across two writes; second waits for first response
    rsp_ready = 1'b1;
    cmd_write = 1'b1; cmd_addr = 32'h2; cmd_wdata = 32'h5555_5555; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    tick();
    t_acc1 = cyc;
    cmd_addr = 32'h3; cmd_wdata = 32'hF0F0_F0F0;
    seen_rsp = 1'b0; first_resp = 2'b11; n = 0;
    while (!cmd_ready && n < 50) begin
      if (rsp_valid) begin seen_rsp = 1'b1; first_resp = rsp_resp; end
      tick(); n++;
    end
    tick();
    t_acc2 = cyc;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("t2_first_rsp_seen", seen_rsp, 1'b1);
    chk("t2_first_rsp_resp", first_resp, 2'b00);
    chk("t2_spacing", t_acc2 - t_acc1, 4);
    wait_rsp(r, d, l);
    chk("t2_second_resp", r, 2'b00);
    issue(1'b0, 32'h2, 32'h0, 4'h0);
    wait_rsp(r, d, l);
    chk("t2_rd2", d, 32'h5555_5555);
    issue(1'b0, 32'h3, 32'h0, 4'h0);
    wait_rsp(r, d, l);
    chk("t2_rd3", d, 32'hF0F0_F0F0);

    // 3: awready in cycle 1, wready in cycle 4
    aw_wait = 0; w_wait = 3;
    issue(1'b1, 32'h4, 32'h1234_5678, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      chk("t3_awvalid", awvalid, (k == 1) ? 1'b1 : 1'b0);
      chk("t3_wvalid", wvalid, 1'b1);
      chk("t3_wdata", wdata, 32'h1234_5678);
      tick();
    end
    chk("t3_wvalid_drop", wvalid, 1'b0);
    wait_rsp(r, d, l);
    chk("t3_lat", l, 16'd5);
    w_wait = 0;

    // 4: response back-pressure
    issue(1'b0, 32'h1, 32'h0, 4'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("t4_rsp_valid", rsp_valid, 1'b1);
      chk("t4_rsp_rdata", rsp_rdata, 32'hAAAA_AAAA);
      chk("t4_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t4_rsp_valid_clr", rsp_valid, 1'b0);
    chk("t4_cmd_ready_back", cmd_ready, 1'b1);

    // 5: reset while waiting for B
    b_wait = 3;
    issue(1'b1, 32'h5, 32'h1111_1111, 4'hF);
    tick();
    chk("t5_in_wr_resp", bready, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_valids", {awvalid, wvalid, arvalid, rsp_valid}, 4'b0000);
    chk("t5_readies", {bready, rready}, 2'b00);
    rst = 1'b0;
    b_wait = 0;
    tick();
    chk("t5_cmd_ready", cmd_ready, 1'b1);
    issue(1'b1, 32'h6, 32'h2222_2222, 4'hF);
    wait_rsp(r, d, l);
    chk("t5_new_wr_resp", r, 2'b00);
    issue(1'b0, 32'h6, 32'h0, 4'h0);
    wait_rsp(r, d, l);
    chk("t5_new_rd", d, 32'h2222_2222);

    // 6: slave error on read
    err_mode = 1'b1;
    issue(1'b0, 32'h7, 32'h0, 4'h0);
    wait_rsp(r, d, l);
    chk("t6_resp", r, 2'b10);
    chk("t6_rdata", d, 32'hDEAD_BEEF);
    err_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
